// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared definitions for the Spartan-6 outbound TLP path: header encodings,
// latched header record and the header-DW formatter.
package dlsc_pcie_s6_pkg;

    localparam logic [1:0] FMT_MRD3 = 2'b00;
    localparam logic [1:0] FMT_MRD4 = 2'b01;
    localparam logic [1:0] FMT_MWR3 = 2'b10;
    localparam logic [1:0] FMT_MWR4 = 2'b11;
    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam int         HDR_IDX_W = 2;

    typedef enum logic [1:0] {ST_ARB, ST_HDR, ST_DATA} state_t;

    // DW address is held at full 62-bit width regardless of ADDR
    typedef struct packed {
        logic        write;
        logic        is4dw;
        logic [61:0] addr;
        logic [9:0]  len;
        logic [7:0]  tag;
        logic [3:0]  be_first;
        logic [3:0]  be_last;
    } hdr_t;

    function automatic logic [10:0] len_to_cnt(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

    function automatic logic [1:0] fmt_of(input logic write, input logic is4dw);
        case ({write, is4dw})
            2'b00:   return FMT_MRD3;
            2'b01:   return FMT_MRD4;
            2'b10:   return FMT_MWR3;
            default: return FMT_MWR4;
        endcase
    endfunction

    function automatic logic [31:0] hdr_word(input hdr_t h, input logic [HDR_IDX_W-1:0] idx,
                                             input logic [15:0] rid);
        case (idx)
            2'd0:    return {1'b0, fmt_of(h.write, h.is4dw), TYPE_MEM, 14'd0, h.len};
            2'd1:    return {rid, h.tag, h.be_last, h.be_first};
            2'd2:    return h.is4dw ? h.addr[61:30] : {h.addr[29:0], 2'b00};
            default: return {h.addr[29:0], 2'b00};
        endcase
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_tlp_arb.sv
// CHANNELS-wide request arbiter with one-hot grant.
// DLSC_PCIE_S6_TLP_MUX_RR_EN selects round-robin; otherwise fixed lowest-index priority.
module dlsc_pcie_s6_tlp_arb #(
    parameter int CHANNELS = 2
) (
`ifdef DLSC_PCIE_S6_TLP_MUX_RR_EN
    input  logic                clk,
    input  logic                rst_n,
    input  logic                advance,
`endif
    input  logic [CHANNELS-1:0] req,
    output logic [CHANNELS-1:0] gnt
);

`ifdef DLSC_PCIE_S6_TLP_MUX_RR_EN
    // mask[i] set for every channel at or above the pointer
    logic [CHANNELS-1:0] mask, mask_nxt, pick;
    logic                found, seen;

    always_comb begin
        pick = ((req & mask) != '0) ? (req & mask) : req;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pick[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        mask_nxt = '0;
        seen     = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            mask_nxt[i] = seen;
            if (gnt[i]) seen = 1'b1;
        end
        if (mask_nxt == '0) mask_nxt = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       mask <= '1;
        else if (advance) mask <= mask_nxt;
    end
`else
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dlsc_pcie_s6_outbound_tlp_mux.sv
// N-channel MRd/MWr TLP arbiter/formatter feeding the Spartan-6 PCIe TX stream.
// Arbitration mode chosen by DLSC_PCIE_S6_TLP_MUX_RR_EN (see dlsc_pcie_s6_tlp_arb).
module dlsc_pcie_s6_outbound_tlp_mux
    import dlsc_pcie_s6_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int TAG      = 5,
    parameter int ADDR     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dma_en,
    input  logic [7:0]                 bus_number,
    input  logic [4:0]                 dev_number,
    input  logic [2:0]                 func_number,
    output logic [CHANNELS-1:0]        ch_h_ready,
    input  logic [CHANNELS-1:0]        ch_h_valid,
    input  logic [CHANNELS-1:0]        ch_h_write,
    input  logic [CHANNELS*(ADDR-2)-1:0] ch_h_addr,
    input  logic [CHANNELS*10-1:0]     ch_h_len,
    input  logic [CHANNELS*TAG-1:0]    ch_h_tag,
    input  logic [CHANNELS*4-1:0]      ch_h_be_first,
    input  logic [CHANNELS*4-1:0]      ch_h_be_last,
    output logic [CHANNELS-1:0]        ch_d_ready,
    input  logic [CHANNELS-1:0]        ch_d_valid,
    input  logic [CHANNELS*32-1:0]     ch_d_data,
    input  logic                       tx_ready,
    output logic                       tx_valid,
    output logic [31:0]                tx_data,
    output logic                       tx_last
);

    state_t                 state, state_nxt;
    logic [CHANNELS-1:0]    req, gnt, cur;
    logic                   take, out_free, d_fire;
    hdr_t                   sel, h;
    logic [HDR_IDX_W-1:0]   idx, idx_nxt, last_idx;
    logic [10:0]            cnt, cnt_nxt;
    logic                   ld, ld_last;
    logic [31:0]            ld_word, d_sel;
    logic [15:0]            rid;

    assign rid      = {bus_number, dev_number, func_number};
    assign out_free = !tx_valid || tx_ready;
    assign req      = ch_h_valid & {CHANNELS{dma_en}};
    assign take     = rst_n && (state == ST_ARB) && out_free && (req != '0);
    assign ch_h_ready = take ? gnt : '0;
    assign ch_d_ready = (rst_n && (state == ST_DATA) && out_free) ? cur : '0;
    assign d_fire   = (ch_d_ready & ch_d_valid) != '0;
    assign last_idx = h.is4dw ? 2'd3 : 2'd2;

    dlsc_pcie_s6_tlp_arb #(.CHANNELS(CHANNELS)) u_arb (
`ifdef DLSC_PCIE_S6_TLP_MUX_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (take),
`endif
        .req     (req),
        .gnt     (gnt)
    );

    // Header fields of the current winner, and payload of the owning channel
    always_comb begin
        sel   = '0;
        d_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt[i]) begin
                sel.write    = ch_h_write[i];
                sel.addr     = 62'(ch_h_addr[i*(ADDR-2) +: (ADDR-2)]);
                sel.len      = ch_h_len[i*10 +: 10];
                sel.tag      = 8'(ch_h_tag[i*TAG +: TAG]);
                sel.be_first = ch_h_be_first[i*4 +: 4];
                sel.be_last  = ch_h_be_last[i*4 +: 4];
            end
            if (cur[i]) d_sel = ch_d_data[i*32 +: 32];
        end
        sel.is4dw = |sel.addr[61:30];
        if (sel.len == 10'd1) sel.be_last = 4'd0;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        ld        = 1'b0;
        ld_word   = '0;
        ld_last   = 1'b0;
        case (state)
            ST_ARB: begin
                if (take) begin
                    ld        = 1'b1;
                    ld_word   = hdr_word(sel, 2'd0, rid);
                    idx_nxt   = 2'd1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_word = hdr_word(h, idx, rid);
                    if (idx == last_idx) begin
                        ld_last   = !h.write;
                        cnt_nxt   = len_to_cnt(h.len);
                        state_nxt = h.write ? ST_DATA : ST_ARB;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (d_fire) begin
                    ld      = 1'b1;
                    ld_word = d_sel;
                    ld_last = (cnt == 11'd1);
                    cnt_nxt = cnt - 11'd1;
                    if (cnt == 11'd1) state_nxt = ST_ARB;
                end
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_ARB;
            idx      <= '0;
            cnt      <= '0;
            h        <= '0;
            cur      <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_data  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                h   <= sel;
                cur <= gnt;
            end
            // ld only happens with out_free, so a stalled word is never overwritten
            if (ld) begin
                tx_valid <= 1'b1;
                tx_data  <= ld_word;
                tx_last  <= ld_last;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_tlp_mux.sv
// Self-checking bench for dlsc_pcie_s6_outbound_tlp_mux (both arbitration builds).
module tb_dlsc_pcie_s6_outbound_tlp_mux;
    localparam int CHANNELS = 2;
    localparam int TAG      = 5;
    localparam int ADDR     = 64;

    logic clk = 1'b0, rst_n = 1'b0, dma_en = 1'b0;
    logic [7:0] bus_number = 8'd1;
    logic [4:0] dev_number = 5'd2;
    logic [2:0] func_number = 3'd0;
    logic [CHANNELS-1:0] ch_h_ready, ch_h_valid = '0, ch_h_write = '0;
    logic [CHANNELS*(ADDR-2)-1:0] ch_h_addr = '0;
    logic [CHANNELS*10-1:0] ch_h_len = '0;
    logic [CHANNELS*TAG-1:0] ch_h_tag = '0;
    logic [CHANNELS*4-1:0] ch_h_be_first = '0, ch_h_be_last = '0;
    logic [CHANNELS-1:0] ch_d_ready, ch_d_valid = '0;
    logic [CHANNELS*32-1:0] ch_d_data = '0;
    logic tx_ready = 1'b0, tx_valid, tx_last;
    logic [31:0] tx_data;

    dlsc_pcie_s6_outbound_tlp_mux #(.CHANNELS(CHANNELS), .TAG(TAG), .ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .dma_en(dma_en), .bus_number(bus_number),
        .dev_number(dev_number), .func_number(func_number),
        .ch_h_ready(ch_h_ready), .ch_h_valid(ch_h_valid), .ch_h_write(ch_h_write),
        .ch_h_addr(ch_h_addr), .ch_h_len(ch_h_len), .ch_h_tag(ch_h_tag),
        .ch_h_be_first(ch_h_be_first), .ch_h_be_last(ch_h_be_last),
        .ch_d_ready(ch_d_ready), .ch_d_valid(ch_d_valid), .ch_d_data(ch_d_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0, errors = 0;
    int gnt_cnt = 0;
    int g_cyc;
    logic [32:0] got[$];
    int got_t[$];
    logic [32:0] exp_q[$];
    logic [31:0] pay[$];

    // Sink monitor: a word seen valid&ready here is taken on the next rising edge
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            got.push_back({tx_last, tx_data});
            got_t.push_back(cyc);
        end
        if (ch_h_ready != '0) gnt_cnt++;
    end

    task automatic set_hdr(input int ch, input bit wr, input logic [63:0] addr, input int len,
                           input int tag, input logic [3:0] bef, input logic [3:0] bel);
        ch_h_write[ch] = wr;
        ch_h_addr[ch*(ADDR-2) +: (ADDR-2)] = addr[63:2];
        ch_h_len[ch*10 +: 10] = 10'(len);
        ch_h_tag[ch*TAG +: TAG] = TAG'(tag);
        ch_h_be_first[ch*4 +: 4] = bef;
        ch_h_be_last[ch*4 +: 4] = bel;
    endtask

    // Expected TLP from the header rules, plus a fresh random payload
    task automatic build_exp(input bit wr, input logic [63:0] addr, input int len, input int tag,
                             input logic [3:0] bef, input logic [3:0] bel);
        int n;
        bit four;
        logic [31:0] w;
        n = (len == 0) ? 1024 : len;
        four = (addr >> 32) != 0;
        exp_q.delete();
        pay.delete();
        w = (32'(wr) << 30) | (32'(four) << 29) | 32'(len % 1024);
        exp_q.push_back({1'b0, w});
        w = (32'(bus_number) << 24) | (32'(dev_number) << 19) | (32'(func_number) << 16) |
            (32'(tag) << 8) | ((n == 1) ? 32'd0 : (32'(bel) << 4)) | 32'(bef);
        exp_q.push_back({1'b0, w});
        if (four) exp_q.push_back({1'b0, 32'(addr >> 32)});
        exp_q.push_back({!wr, 32'(addr % 64'h1_0000_0000) & 32'hFFFF_FFFC});
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                pay.push_back(w);
                exp_q.push_back({(k == n - 1), w});
            end
        end
    endtask

    task automatic do_tlp(input string name, input int ch, input bit wr, input logic [63:0] addr,
                          input int len, input int tag, input logic [3:0] bef, input logic [3:0] bel,
                          input bit rnd, input bit drop_dma);
        bit stray;
        int k, nh, o;
        stray = 1'b0;
        k = 0;
        o = (ch + 1) % CHANNELS;
        nh = ((addr >> 32) != 0) ? 4 : 3;
        build_exp(wr, addr, len, tag, bef, bel);
        got.delete();
        got_t.delete();
        g_cyc = -1;
        fork
            begin
                @(posedge clk); #1;
                set_hdr(ch, wr, addr, len, tag, bef, bel);
                ch_h_valid[ch] = 1'b1;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (ch_h_ready[ch]) begin g_cyc = cyc; break; end
                end
                @(posedge clk); #1;
                ch_h_valid[ch] = 1'b0;
                if (drop_dma) begin
                    dma_en = 1'b0;
                    set_hdr(o, 1'b0, 64'h3000, 1, 1, 4'hF, 4'hF);
                    ch_h_valid[o] = 1'b1;
                end
            end
            begin
                if (wr) begin
                    for (int t = 0; t < 8000 && k < pay.size(); t++) begin
                        @(posedge clk); #1;
                        ch_d_valid[ch] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                        ch_d_data[ch*32 +: 32] = pay[k];
                        @(negedge clk);
                        if ((ch_d_ready & ~(CHANNELS'(1) << ch)) != '0) stray = 1'b1;
                        if (ch_d_valid[ch] && ch_d_ready[ch]) k++;
                    end
                    @(posedge clk); #1;
                    ch_d_valid[ch] = 1'b0;
                end
            end
            begin
                for (int t = 0; t < 8000 && got.size() < exp_q.size(); t++) begin
                    @(posedge clk); #1;
                    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                tx_ready = 1'b1;
            end
        join
        vectors++;
        if (g_cyc < 0) begin errors++; $display("FAIL %s_grant: no ch_h_ready seen, expected one", name); end
        vectors++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_count: got %0d words, expected %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL %s_word%0d: got last/data %h, expected %h", name, i, got[i], exp_q[i]);
            end
        end
        if (!rnd && g_cyc >= 0 && got_t.size() >= nh) begin
            vectors++;
            if (got_t[0] !== g_cyc + 1) begin
                errors++; $display("FAIL %s_latency: DW0 at cycle %0d, expected %0d", name, got_t[0], g_cyc + 1);
            end
            for (int i = 1; i < nh; i++) begin
                vectors++;
                if (got_t[i] !== got_t[0] + i) begin
                    errors++; $display("FAIL %s_hdr_gap%0d: cycle %0d, expected %0d", name, i, got_t[i], got_t[0] + i);
                end
            end
        end
        if (wr) begin
            vectors++;
            if (stray) begin errors++; $display("FAIL %s_d_ready: stray ch_d_ready 1, expected 0", name); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; dma_en = 1'b1; ch_h_valid = '1; ch_d_valid = '1; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 5;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
        if (tx_last !== 1'b0) begin errors++; $display("FAIL rst_tx_last: got %b expected 0", tx_last); end
        if (tx_data !== 32'd0) begin errors++; $display("FAIL rst_tx_data: got %h expected 0", tx_data); end
        if (ch_h_ready !== '0) begin errors++; $display("FAIL rst_h_ready: got %b expected 0", ch_h_ready); end
        if (ch_d_ready !== '0) begin errors++; $display("FAIL rst_d_ready: got %b expected 0", ch_d_ready); end
        @(posedge clk); #1;
        ch_h_valid = '0; ch_d_valid = '0; tx_ready = 1'b1; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_tx_valid: got %b expected 0", tx_valid); end
    endtask

    task automatic test_arb;
        int gi[$], gt[$];
        int idx, want;
        for (int i = 0; i < CHANNELS; i++) set_hdr(i, 1'b0, 64'h100 * (i + 1), 2, i, 4'hF, 4'hF);
        @(posedge clk); #1;
        ch_h_valid = '1;
        for (int t = 0; t < 60 && gi.size() < 2 * CHANNELS + 1; t++) begin
            @(negedge clk);
            if (ch_h_ready != '0) begin
                vectors++;
                if ($countones(ch_h_ready) != 1) begin
                    errors++; $display("FAIL arb_onehot: got %b expected one-hot", ch_h_ready);
                end
                idx = 0;
                for (int i = 0; i < CHANNELS; i++) if (ch_h_ready[i]) idx = i;
                gi.push_back(idx);
                gt.push_back(cyc);
            end
        end
        @(posedge clk); #1;
        ch_h_valid = '0;
        repeat (12) @(posedge clk);
        #1;
        got.delete(); got_t.delete();
        vectors++;
        if (gi.size() != 2 * CHANNELS + 1) begin
            errors++; $display("FAIL arb_grants: got %0d grants, expected %0d", gi.size(), 2 * CHANNELS + 1);
        end
        for (int k = 0; k < gi.size(); k++) begin
`ifdef DLSC_PCIE_S6_TLP_MUX_RR_EN
            want = k % CHANNELS;
`else
            want = 0;
`endif
            vectors++;
            if (gi[k] != want) begin errors++; $display("FAIL arb_order%0d: got ch %0d expected ch %0d", k, gi[k], want); end
            if (k > 0) begin
                vectors++;
                if (gt[k] - gt[k-1] != 3) begin
                    errors++; $display("FAIL arb_spacing%0d: got %0d cycles expected 3", k, gt[k] - gt[k-1]);
                end
            end
        end
    endtask

    task automatic test_mrd;
        logic [32:0] c[3];
        logic [32:0] w;
        c = '{33'h0_0000_0004, 33'h0_0110_03FF, 33'h1_0000_1000};
        bus_number = 8'd1; dev_number = 5'd2; func_number = 3'd0;
        do_tlp("mrd", 0, 1'b0, 64'h1000, 4, 3, 4'hF, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            w = (i < got.size()) ? got[i] : 'x;
            vectors++;
            if (w !== c[i]) begin errors++; $display("FAIL mrd_const%0d: got %h expected %h", i, w, c[i]); end
        end
    endtask

    task automatic test_mwr4;
        logic [32:0] w;
        do_tlp("mwr4", 1, 1'b1, 64'h1_2000_0000, 1, 0, 4'hF, 4'hF, 1'b0, 1'b0);
        w = (got.size() == 5) ? got[0] : 'x;
        vectors++;
        if (w !== 33'h0_6000_0001) begin errors++; $display("FAIL mwr4_dw0: got %h expected 060000001", w); end
        w = (got.size() == 5) ? got[1] : 'x;
        vectors++;
        if (w[7:4] !== 4'h0) begin errors++; $display("FAIL mwr4_be_last: got %h expected 0", w[7:4]); end
        w = (got.size() == 5) ? got[2] : 'x;
        vectors++;
        if (w !== 33'h0_0000_0001) begin errors++; $display("FAIL mwr4_dw2: got %h expected 000000001", w); end
        w = (got.size() == 5) ? got[3] : 'x;
        vectors++;
        if (w !== 33'h0_2000_0000) begin errors++; $display("FAIL mwr4_dw3: got %h expected 020000000", w); end
    endtask

    task automatic test_random;
        logic [63:0] a;
        for (int it = 0; it < 10; it++) begin
            a = ($urandom_range(0, 1) != 0) ? {32'($urandom), 32'($urandom)} : {32'd0, 32'($urandom)};
            a[1:0] = 2'b00;
            bus_number = 8'($urandom); dev_number = 5'($urandom); func_number = 3'($urandom);
            do_tlp($sformatf("rnd%0d", it), $urandom_range(0, CHANNELS - 1), 1'($urandom_range(0, 1)), a,
                   $urandom_range(1, 12), $urandom_range(0, 31), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
        end
    endtask

    task automatic test_len0;
        int lasts;
        do_tlp("len0", 0, 1'b1, 64'h8000, 0, 7, 4'hF, 4'hF, 1'b1, 1'b0);
        lasts = 0;
        foreach (got[i]) if (got[i][32]) lasts++;
        vectors++;
        if (lasts != 1) begin errors++; $display("FAIL len0_lasts: got %0d tx_last words expected 1", lasts); end
    endtask

    task automatic test_dma;
        int g0, seen;
        dma_en = 1'b0;
        set_hdr(0, 1'b0, 64'h500, 2, 1, 4'hF, 4'hF);
        set_hdr(1, 1'b0, 64'h600, 2, 2, 4'hF, 4'hF);
        @(posedge clk); #1;
        ch_h_valid = '1;
        seen = 0;
        repeat (20) begin @(negedge clk); if (ch_h_ready != '0) seen++; end
        vectors++;
        if (seen != 0) begin errors++; $display("FAIL dma_block: got %0d grants expected 0", seen); end
        @(posedge clk); #1;
        ch_h_valid = '0;
        dma_en = 1'b1;
        g0 = gnt_cnt;
        do_tlp("dma_drop", 0, 1'b1, 64'h7000, 8, 5, 4'hF, 4'h3, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (gnt_cnt != g0 + 1) begin errors++; $display("FAIL dma_after: got %0d grants expected %0d", gnt_cnt - g0, 1); end
        ch_h_valid = '0;
        dma_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int k;
        bit granted;
        logic [32:0] w;
        got.delete(); got_t.delete();
        tx_ready = 1'b1;
        granted = 1'b0;
        @(posedge clk); #1;
        set_hdr(0, 1'b1, 64'h4000, 16, 2, 4'hF, 4'hF);
        ch_h_valid[0] = 1'b1;
        for (int t = 0; t < 100 && !granted; t++) begin @(negedge clk); granted = ch_h_ready[0]; end
        @(posedge clk); #1;
        ch_h_valid[0] = 1'b0;
        k = 0;
        for (int t = 0; t < 100 && k < 4; t++) begin
            ch_d_valid[0] = 1'b1;
            ch_d_data[31:0] = 32'hA000 + k;
            @(negedge clk);
            if (ch_d_ready[0]) k++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        ch_d_valid = '0;
        @(posedge clk);
        @(negedge clk);
        vectors += 3;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid: got %b expected 0", tx_valid); end
        if (tx_last !== 1'b0) begin errors++; $display("FAIL rmid_tx_last: got %b expected 0", tx_last); end
        if (ch_d_ready !== '0) begin errors++; $display("FAIL rmid_d_ready: got %b expected 0", ch_d_ready); end
        w = (got.size() > 0) ? got[0] : 'x;
        vectors++;
        if (w !== 33'h0_4000_0010) begin errors++; $display("FAIL rmid_dw0: got %h expected 040000010", w); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_tlp("post_rst", 1, 1'b0, 64'h2000, 4, 9, 4'hF, 4'hF, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_arb();
        test_mrd();
        test_mwr4();
        test_random();
        test_len0();
        test_dma();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
